rvga_ddr_arbiter: RTL



---
 rtl/rvga_ddr_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rvga_ddr_arbiter.sv
// -----------------------------------------------------------------------------
// rvga_ddr_arbiter
//
// Shares one DDR request/response port between the core's instruction-fetch
// path (read-only) and its data path (read/write). One transaction is in
// flight at a time: the winning request is latched in IDLE, driven to DDR
// while busy, and the DDR response is routed back combinationally to its
// owner. Ties are broken round-robin; a watchdog ends a transaction that DDR
// never answers, returning TIMEOUT_DATA and setting a sticky error flag.
//
// Parameters
//   TIMEOUT      : busy cycles allowed before the watchdog fires (0 = off)
//   TIMEOUT_DATA : read data returned on a watchdog-terminated transaction
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   i_addr, i_read               : fetch request
//   i_rdata, i_resp              : fetch response (resp is a one-cycle pulse)
//   d_addr, d_read, d_write,
//   d_wdata                      : data request
//   d_rdata, d_resp              : data response (resp is a one-cycle pulse)
//   ddr_addr, ddr_read,
//   ddr_write, ddr_wdata         : request towards DDR
//   ddr_rdata, ddr_resp          : response from DDR
//   err                          : sticky watchdog error
// -----------------------------------------------------------------------------
module rvga_ddr_arbiter #(
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_addr,
    input  logic        i_read,
    output logic [31:0] i_rdata,
    output logic        i_resp,

    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,

    output logic [31:0] ddr_addr,
    output logic        ddr_read,
    output logic        ddr_write,
    output logic [31:0] ddr_wdata,
    input  logic [31:0] ddr_rdata,
    input  logic        ddr_resp,

    output logic        err
);

    // Watchdog counter is wide enough to reach TIMEOUT; at least one bit so
    // the design still elaborates with the watchdog disabled.
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   op_addr, op_wdata;
    logic          op_we;
    logic          prio;          // 0: data wins a tie, 1: fetch wins a tie
    logic [CW-1:0] cnt;
    logic [31:0]   i_rdata_q, d_rdata_q;

    logic          fetch_req, data_req;
    logic          grant_i, grant_d;
    logic          busy, done, tmo;
    logic [31:0]   resp_data;

    assign fetch_req = i_read;
    assign data_req  = d_read | d_write;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        resp_data = ddr_rdata;
        ddr_addr  = '0;
        ddr_wdata = '0;
        ddr_read  = 1'b0;
        ddr_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (fetch_req && (!data_req || prio)) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end else if (data_req) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                ddr_addr  = op_addr;
                ddr_wdata = op_wdata;
                ddr_write = op_we;
                ddr_read  = ~op_we;
                // A real DDR response takes precedence over the watchdog
                // when both land in the same cycle.
                if (ddr_resp) begin
                    done = 1'b1;
                end else if (TIMEOUT != 0 && cnt == CNT_LIMIT) begin
                    done = 1'b1;
                    tmo  = 1'b1;
                end
                resp_data = ddr_resp ? ddr_rdata : TIMEOUT_DATA;
                // Reset aborts silently: no response pulse in the reset cycle.
                if (done && !rst) begin
                    state_d = IDLE;
                    if (state_q == BUSY_I) begin
                        i_resp  = 1'b1;
                        i_rdata = resp_data;
                    end else begin
                        d_resp  = 1'b1;
                        d_rdata = resp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_addr   <= '0;
            op_wdata  <= '0;
            op_we     <= 1'b0;
            prio      <= 1'b0;
            cnt       <= '0;
            err       <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;

            // Latch the winner; the loser keeps requesting and gets the
            // next tie because prio now points at it.
            if (grant_i) begin
                op_addr  <= i_addr;
                op_wdata <= '0;
                op_we    <= 1'b0;
                prio     <= 1'b0;
                cnt      <= '0;
            end else if (grant_d) begin
                op_addr  <= d_addr;
                op_wdata <= d_wdata;
                op_we    <= d_write;
                prio     <= 1'b1;
                cnt      <= '0;
            end

            // Saturating so a disabled watchdog never wraps.
            if (busy && !done && cnt != '1)
                cnt <= cnt + 1'b1;

            if (i_resp)
                i_rdata_q <= i_rdata;
            if (d_resp)
                d_rdata_q <= d_rdata;
            if (tmo)
                err <= 1'b1;
        end
    end

endmodule
